// File: rtl/led_activity_scheduler.sv
// led_activity_scheduler: one board LED shared by error blink, button,
// UART activity flash and 1 Hz heartbeat, highest priority first.
module led_activity_scheduler #(
   parameter int unsigned CNT_W     = 32,
   parameter int unsigned HB_HALF   = 6_000_000,
   parameter int unsigned FLASH_ON  = 600_000,
   parameter int unsigned FLASH_GAP = 600_000,
   parameter int unsigned ERR_HALF  = 1_200_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   input  logic       tx_evt,
   input  logic       rx_evt,
   input  logic       err,
   output logic       led,
   output logic [7:0] flash_cnt
);

   typedef enum logic [2:0] {
      HB,
      FLASH,
      GAP,
      BTN,
      ERR
   } state_t;

   localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] HB_LAST = CNT_W'(HB_HALF - 1);
   localparam logic [CNT_W-1:0] FL_LAST = CNT_W'(FLASH_ON - 1);
   localparam logic [CNT_W-1:0] GP_LAST = CNT_W'(FLASH_GAP - 1);
   localparam logic [CNT_W-1:0] ER_LAST = CNT_W'(ERR_HALF - 1);

   state_t           state;
   state_t           state_nxt;
   logic [CNT_W-1:0] hb_cnt;
   logic [CNT_W-1:0] t_cnt;
   logic [CNT_W-1:0] t_cnt_nxt;
   logic             hb_phase;
   logic             hb_phase_nxt;
   logic             hb_wrap;
   logic             pending;
   logic             pending_nxt;
   logic             led_nxt;
   logic [7:0]       flash_cnt_nxt;
   logic             evt;
   logic             pend_any;
   logic             flash_go;
   logic             btn_q1;
   logic             btn_s;

   assign evt          = tx_evt | rx_evt;
   assign pend_any     = pending | evt;
   assign hb_wrap      = (hb_cnt == HB_LAST);
   assign hb_phase_nxt = hb_phase ^ hb_wrap;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_q1    <= 1'b0;
         btn_s     <= 1'b0;
         hb_cnt    <= '0;
         hb_phase  <= 1'b0;
         t_cnt     <= '0;
         pending   <= 1'b0;
         state     <= HB;
         led       <= 1'b0;
         flash_cnt <= 8'd0;
      end else begin
         btn_q1    <= btn;
         btn_s     <= btn_q1;
         hb_cnt    <= hb_wrap ? '0 : hb_cnt + ONE;
         hb_phase  <= hb_phase_nxt;
         t_cnt     <= t_cnt_nxt;
         pending   <= pending_nxt;
         state     <= state_nxt;
         led       <= led_nxt;
         flash_cnt <= flash_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      led_nxt       = led;
      t_cnt_nxt     = t_cnt + ONE;
      pending_nxt   = pending | evt;
      flash_cnt_nxt = flash_cnt;
      flash_go      = 1'b0;
      if (err) begin
         state_nxt = ERR;
         if (state != ERR) begin
            led_nxt   = 1'b1;
            t_cnt_nxt = '0;
         end else if (t_cnt == ER_LAST) begin
            led_nxt   = ~led;
            t_cnt_nxt = '0;
         end
      end else if (btn_s) begin
         state_nxt = BTN;
         led_nxt   = 1'b1;
         t_cnt_nxt = '0;
      end else begin
         case (state)
            HB: begin
               led_nxt   = hb_phase_nxt;
               t_cnt_nxt = '0;
               flash_go  = pend_any;
            end
            FLASH: begin
               led_nxt = 1'b1;
               if (t_cnt == FL_LAST) begin
                  state_nxt = GAP;
                  led_nxt   = 1'b0;
                  t_cnt_nxt = '0;
               end
            end
            GAP: begin
               led_nxt = 1'b0;
               if (t_cnt == GP_LAST) begin
                  flash_go  = pend_any;
                  state_nxt = HB;
                  led_nxt   = hb_phase_nxt;
                  t_cnt_nxt = '0;
               end
            end
            default: begin
               state_nxt = HB;
               led_nxt   = hb_phase_nxt;
               t_cnt_nxt = '0;
            end
         endcase
         // the registered request is consumed; a same-cycle event re-arms it
         if (flash_go) begin
            state_nxt     = FLASH;
            led_nxt       = 1'b1;
            t_cnt_nxt     = '0;
            pending_nxt   = pending & evt;
            flash_cnt_nxt = flash_cnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_led_activity_scheduler.sv
// tb_led_activity_scheduler: directed vectors with hand-derived LED
// timelines for heartbeat, flash, error, button, reset and wrap.
module tb_led_activity_scheduler;

   logic       clk    = 1'b0;
   logic       rst_n  = 1'b0;
   logic       btn    = 1'b0;
   logic       tx_evt = 1'b0;
   logic       rx_evt = 1'b0;
   logic       err    = 1'b0;
   logic       led;
   logic [7:0] flash_cnt;

   int nvec = 0;
   int nbad = 0;
   int cyc  = 0;

   led_activity_scheduler #(
      .CNT_W    (32),
      .HB_HALF  (10),
      .FLASH_ON (4),
      .FLASH_GAP(3),
      .ERR_HALF (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .btn      (btn),
      .tx_evt   (tx_evt),
      .rx_evt   (rx_evt),
      .err      (err),
      .led      (led),
      .flash_cnt(flash_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] got,
                      input logic [7:0] exp);
      nvec++;
      assert (got === exp) else begin
         nbad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_led(input string tag, input logic e);
      chk($sformatf("%s c%0d", tag, cyc), {7'd0, led}, {7'd0, e});
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1;
      rst_n  = 1'b0;
      btn    = 1'b0;
      tx_evt = 1'b0;
      rx_evt = 1'b0;
      err    = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst led", {7'd0, led}, 8'd0);
      chk("rst flash_cnt", flash_cnt, 8'd0);
      rst_n = 1'b1;
      cyc   = 0;
   endtask

   function automatic logic hb(input int k);
      return ((k / 10) % 2) == 1;
   endfunction

   function automatic logic exp2(input int k);
      if (k >= 6 && k <= 9) return 1'b1;
      if (k >= 10 && k <= 12) return 1'b0;
      return hb(k);
   endfunction

   function automatic logic exp3(input int k);
      if (k >= 3 && k <= 6) return 1'b1;
      if (k >= 7 && k <= 9) return 1'b0;
      if (k >= 10 && k <= 13) return 1'b1;
      if (k >= 14 && k <= 16) return 1'b0;
      if (k >= 23 && k <= 26) return 1'b1;
      if (k >= 27 && k <= 29) return 1'b0;
      if (k >= 30 && k <= 33) return 1'b1;
      if (k >= 34 && k <= 36) return 1'b0;
      return hb(k);
   endfunction

   function automatic logic exp4(input int k);
      if (k == 11 || k == 12) return 1'b1;
      if (k >= 13 && k <= 21) return ((k - 13) % 4) < 2;
      if (k >= 23 && k <= 26) return 1'b1;
      if (k >= 27 && k <= 29) return 1'b0;
      return hb(k);
   endfunction

   function automatic logic exp5(input int k);
      if (k == 15 || k == 16) return 1'b1;
      if (k == 17 || k == 18) return 1'b0;
      if (k >= 19 && k <= 22) return 1'b1;
      if (k == 27 || k == 28) return 1'b1;
      return hb(k);
   endfunction

   initial begin
      // heartbeat only
      do_reset();
      chk_led("t1", 1'b0);
      while (cyc < 40) begin
         step();
         chk_led("t1", hb(cyc));
      end
      chk("t1 flash_cnt", flash_cnt, 8'd0);

      // single tx pulse
      do_reset();
      while (cyc < 25) begin
         tx_evt = (cyc == 5);
         step();
         chk_led("t2", exp2(cyc));
      end
      chk("t2 flash_cnt", flash_cnt, 8'd1);

      // coalescing
      do_reset();
      while (cyc < 45) begin
         tx_evt = (cyc == 2) || (cyc >= 22 && cyc <= 26);
         rx_evt = (cyc == 2) || (cyc == 4);
         step();
         chk_led("t3", exp3(cyc));
         if (cyc == 20) chk("t3 flash_cnt mid", flash_cnt, 8'd2);
      end
      chk("t3 flash_cnt", flash_cnt, 8'd4);

      // error interrupts a flash
      do_reset();
      while (cyc < 40) begin
         tx_evt = (cyc == 10);
         rx_evt = (cyc == 15);
         err    = (cyc >= 12 && cyc <= 20);
         step();
         chk_led("t4", exp4(cyc));
      end
      chk("t4 flash_cnt", flash_cnt, 8'd2);

      // button vs error, then button alone
      do_reset();
      while (cyc < 35) begin
         err = (cyc >= 14 && cyc <= 17);
         btn = (cyc >= 14 && cyc <= 19) || (cyc >= 24 && cyc <= 25);
         step();
         chk_led("t5", exp5(cyc));
      end
      chk("t5 flash_cnt", flash_cnt, 8'd0);

      // async reset mid-flash
      do_reset();
      while (cyc < 5) begin
         tx_evt = (cyc == 2);
         rx_evt = (cyc == 4);
         step();
         chk_led("t6a", exp2(cyc + 3));
      end
      rst_n = 1'b0;
      #2;
      chk("t6a async led", {7'd0, led}, 8'd0);
      chk("t6a async flash_cnt", flash_cnt, 8'd0);

      // async reset mid-gap with pending set
      do_reset();
      while (cyc < 8) begin
         tx_evt = (cyc == 2);
         rx_evt = (cyc == 4);
         step();
         chk_led("t6b", exp3(cyc));
      end
      chk("t6b pre flash_cnt", flash_cnt, 8'd1);
      rst_n  = 1'b0;
      tx_evt = 1'b0;
      rx_evt = 1'b0;
      #2;
      chk("t6b async led", {7'd0, led}, 8'd0);
      chk("t6b async flash_cnt", flash_cnt, 8'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc   = 0;
      while (cyc < 25) begin
         step();
         chk_led("t6b post", hb(cyc));
      end
      chk("t6b post flash_cnt", flash_cnt, 8'd0);

      // flash counter wrap
      do_reset();
      while (cyc < 1786) begin
         tx_evt = 1'b1;
         step();
         if (cyc == 1) chk("wrap first", flash_cnt, 8'd1);
         if (cyc == 1778) chk("wrap 254", flash_cnt, 8'd254);
         if (cyc == 1779) chk("wrap 255", flash_cnt, 8'd255);
         if (cyc == 1785) chk("wrap hold", flash_cnt, 8'd255);
      end
      chk("wrap zero", flash_cnt, 8'd0);
      chk_led("wrap led", 1'b1);
      tx_evt = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

endmodule
